// File: rtl/msd_requester_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msd_requester_pkg                                            |
// | Description : Shared definitions for the MSD command sequencer: the FSM    |
// |               state encoding, the MSD opcode constants and a helper that   |
// |               classifies the states in which the sequencer waits on the    |
// |               MSD.                                                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package msd_requester_pkg;

    // Sequencer states. The width is fixed so the encoding is explicit.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_WAIT_X = 3'd2,
        ST_LOAD_X = 3'd3,
        ST_WAIT_Y = 3'd4,
        ST_LOAD_Y = 3'd5,
        ST_BUSY   = 3'd6,
        ST_RESP   = 3'd7
    } state_t;

    // MSD operation codes.
    localparam logic [1:0] OP_DIV     = 2'b00;
    localparam logic [1:0] OP_SQRT    = 2'b01;
    localparam logic [1:0] OP_MUL     = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    // States in which the sequencer is blocked on an MSD event. Only these
    // states advance the optional abort timer.
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_WAIT_X) || (s == ST_WAIT_Y) || (s == ST_BUSY);
    endfunction

endpackage : msd_requester_pkg
`default_nettype wire

// File: rtl/msd_req_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msd_req_timer                                                |
// | Description : Wait-state abort timer. Counts cycles while clear is low and |
// |               flags expiry on the LIMIT-th consecutive counted cycle, so   |
// |               the owner leaves the wait state after exactly LIMIT cycles.  |
// | Ports       : clk     - clock, rising edge                                 |
// |               rst     - asynchronous active-low reset                      |
// |               clear   - hold the count at zero (owner not waiting)         |
// |               expired - high during the LIMIT-th waiting cycle             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module msd_req_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] c_last = CW'(LIMIT - 1);

    logic [CW-1:0] r_count;

    // The count saturates at its last value; the owner always leaves the
    // wait state on expiry, which raises clear on the following cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (r_count != c_last) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = !clear && (r_count == c_last);

endmodule : msd_req_timer
`default_nettype wire

// File: rtl/msd_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : msd_requester                                                |
// | Description : Command-side sequencer for the MSD arithmetic unit. Accepts  |
// |               one parallel request (opcode + two operands), pulses start,  |
// |               answers the unit's load_x / load_y prompts with the operands |
// |               on a strobed bus, waits for ready/error and returns result,  |
// |               residue and status on a held valid/ready response channel.   |
// | Ports       : clk, rst            - clock / async active-low reset         |
// |               req_*               - request channel (valid/ready)          |
// |               rsp_*               - response channel (valid held to ready) |
// |               msd_start/load/opcode/data - drive side of the MSD           |
// |               msd_load_x/y, msd_ready_flag, msd_error_flag,                |
// |               msd_result, msd_residue    - MSD status and results          |
// | Options     : MSD_REQ_TIMEOUT_EN - abort a wait state after TIMEOUT_CYCLES |
// |               cycles and report rsp_timeout; otherwise waits are unbounded |
// |               and rsp_timeout is tied low.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module msd_requester
    import msd_requester_pkg::*;
#(
    parameter int WORD_LENGHT = 16
`ifdef MSD_REQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    // Request channel
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_opcode,
    input  logic [WORD_LENGHT-1:0] req_op_x,
    input  logic [WORD_LENGHT-1:0] req_op_y,
    // Response channel
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WORD_LENGHT-1:0] rsp_result,
    output logic [WORD_LENGHT-1:0] rsp_residue,
    output logic                   rsp_error,
    output logic                   rsp_timeout,
    // MSD drive side
    output logic                   msd_start,
    output logic                   msd_load,
    output logic [1:0]             msd_opcode,
    output logic [WORD_LENGHT-1:0] msd_data,
    // MSD status side
    input  logic                   msd_load_x,
    input  logic                   msd_load_y,
    input  logic                   msd_ready_flag,
    input  logic                   msd_error_flag,
    input  logic [WORD_LENGHT-1:0] msd_result,
    input  logic [WORD_LENGHT-1:0] msd_residue
);

    state_t                 r_state;
    logic                   r_req_ready;
    logic [1:0]             r_msd_opcode;
    logic [WORD_LENGHT-1:0] r_op_x;
    logic [WORD_LENGHT-1:0] r_op_y;
    logic [WORD_LENGHT-1:0] r_rsp_result;
    logic [WORD_LENGHT-1:0] r_rsp_residue;
    logic                   r_rsp_error;
    logic                   w_timeout;

    // ------------------------------------------------------------------------
    // Optional wait-state abort timer. Every entry into a wait state comes
    // from a non-wait state, so holding the timer clear outside the wait
    // states restarts it on each entry.
    // ------------------------------------------------------------------------
`ifdef MSD_REQ_TIMEOUT_EN
    logic r_rsp_timeout;
    logic w_timer_clear;

    assign w_timer_clear = !is_wait_state(r_state);

    msd_req_timer #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_timer_clear),
        .expired (w_timeout)
    );

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_timeout   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Sequencer. req_ready is a register rather than a state decode so that
    // it reads low while reset is held, even though the reset state is IDLE.
    // In every MSD wait state the error flag is tested first so that it wins
    // over a simultaneous prompt or ready flag.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b0;
            r_msd_opcode  <= 2'b00;
            r_op_x        <= '0;
            r_op_y        <= '0;
            r_rsp_result  <= '0;
            r_rsp_residue <= '0;
            r_rsp_error   <= 1'b0;
`ifdef MSD_REQ_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_op_x      <= req_op_x;
                        r_op_y      <= req_op_y;
`ifdef MSD_REQ_TIMEOUT_EN
                        r_rsp_timeout <= 1'b0;
`endif
                        if (req_opcode == OP_ILLEGAL) begin
                            // Rejected locally; the MSD never sees it.
                            r_rsp_result  <= '1;
                            r_rsp_residue <= '0;
                            r_rsp_error   <= 1'b1;
                            r_state       <= ST_RESP;
                        end else begin
                            r_msd_opcode <= req_opcode;
                            r_state      <= ST_START;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end

                ST_START: begin
                    r_state <= ST_WAIT_X;
                end

                ST_WAIT_X: begin
                    if (msd_error_flag) begin
                        r_rsp_result  <= msd_result;
                        r_rsp_residue <= msd_residue;
                        r_rsp_error   <= 1'b1;
                        r_state       <= ST_RESP;
                    end else if (msd_load_x) begin
                        r_state <= ST_LOAD_X;
                    end else if (w_timeout) begin
                        r_rsp_result  <= '1;
                        r_rsp_residue <= '0;
                        r_rsp_error   <= 1'b1;
`ifdef MSD_REQ_TIMEOUT_EN
                        r_rsp_timeout <= 1'b1;
`endif
                        r_state       <= ST_RESP;
                    end
                end

                ST_LOAD_X: begin
                    // Square root has a single operand.
                    r_state <= (r_msd_opcode == OP_SQRT) ? ST_BUSY : ST_WAIT_Y;
                end

                ST_WAIT_Y: begin
                    if (msd_error_flag) begin
                        r_rsp_result  <= msd_result;
                        r_rsp_residue <= msd_residue;
                        r_rsp_error   <= 1'b1;
                        r_state       <= ST_RESP;
                    end else if (msd_load_y) begin
                        r_state <= ST_LOAD_Y;
                    end else if (w_timeout) begin
                        r_rsp_result  <= '1;
                        r_rsp_residue <= '0;
                        r_rsp_error   <= 1'b1;
`ifdef MSD_REQ_TIMEOUT_EN
                        r_rsp_timeout <= 1'b1;
`endif
                        r_state       <= ST_RESP;
                    end
                end

                ST_LOAD_Y: begin
                    r_state <= ST_BUSY;
                end

                ST_BUSY: begin
                    if (msd_error_flag || msd_ready_flag) begin
                        r_rsp_result  <= msd_result;
                        r_rsp_residue <= msd_residue;
                        r_rsp_error   <= msd_error_flag;
                        r_state       <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_result  <= '1;
                        r_rsp_residue <= '0;
                        r_rsp_error   <= 1'b1;
`ifdef MSD_REQ_TIMEOUT_EN
                        r_rsp_timeout <= 1'b1;
`endif
                        r_state       <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    // Response registers are untouched here, so the fields
                    // stay stable for as long as the consumer stalls.
                    if (rsp_ready) begin
                        r_msd_opcode <= 2'b00;
                        r_req_ready  <= 1'b1;
                        r_state      <= ST_IDLE;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: registers or decodes of the state register only, so no input
    // reaches an output combinationally.
    // ------------------------------------------------------------------------
    assign req_ready   = r_req_ready;
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_result  = r_rsp_result;
    assign rsp_residue = r_rsp_residue;
    assign rsp_error   = r_rsp_error;

    assign msd_start   = (r_state == ST_START);
    assign msd_load    = (r_state == ST_LOAD_X) || (r_state == ST_LOAD_Y);
    assign msd_opcode  = r_msd_opcode;
    assign msd_data    = (r_state == ST_LOAD_X) ? r_op_x :
                         (r_state == ST_LOAD_Y) ? r_op_y : '0;

endmodule : msd_requester
`default_nettype wire

// File: tb/tb_msd_requester.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_msd_requester                                             |
// | Description : Directed testbench for msd_requester with a small reactive   |
// |               MSD stand-in that prompts for operands, latches them off the |
// |               operand bus and returns arithmetic results.                  |
// | Options     : MSD_REQ_TIMEOUT_EN - also runs the abort-timer scenario with |
// |               TIMEOUT_CYCLES = 8.                                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_msd_requester;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [1:0]   req_opcode;
    logic [W-1:0] req_op_x, req_op_y;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_result, rsp_residue;
    logic         rsp_error, rsp_timeout;
    logic         msd_start, msd_load;
    logic [1:0]   msd_opcode;
    logic [W-1:0] msd_data;
    logic         msd_load_x, msd_load_y, msd_ready_flag, msd_error_flag;
    logic [W-1:0] msd_result, msd_residue;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    msd_requester #(
        .WORD_LENGHT    (W)
`ifdef MSD_REQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_opcode     (req_opcode),
        .req_op_x       (req_op_x),
        .req_op_y       (req_op_y),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_residue    (rsp_residue),
        .rsp_error      (rsp_error),
        .rsp_timeout    (rsp_timeout),
        .msd_start      (msd_start),
        .msd_load       (msd_load),
        .msd_opcode     (msd_opcode),
        .msd_data       (msd_data),
        .msd_load_x     (msd_load_x),
        .msd_load_y     (msd_load_y),
        .msd_ready_flag (msd_ready_flag),
        .msd_error_flag (msd_error_flag),
        .msd_result     (msd_result),
        .msd_residue    (msd_residue)
    );

    // ------------------------------------------------------------------------
    // MSD stand-in. Runs on the falling edge so its outputs are settled well
    // before the requester samples them.
    // ------------------------------------------------------------------------
    int         stub_latency = 2;
    bit         stub_never_x = 1'b0;
    int         n_start = 0;
    int         n_load  = 0;
    int         n_leak  = 0;
    logic [1:0] st_s;
    logic [1:0] st_op;
    int         st_cnt;
    logic [W-1:0] st_x, st_y;

    function automatic logic [W-1:0] isqrt(input logic [W-1:0] v);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return W'(r);
    endfunction

    function automatic logic [W-1:0] smul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        return p[W-1:0];
    endfunction

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            st_s           <= 2'd0;
            st_op          <= 2'd0;
            st_cnt         <= 0;
            st_x           <= '0;
            st_y           <= '0;
            msd_load_x     <= 1'b0;
            msd_load_y     <= 1'b0;
            msd_ready_flag <= 1'b0;
            msd_error_flag <= 1'b0;
            msd_result     <= '0;
            msd_residue    <= '0;
        end else begin
            msd_ready_flag <= 1'b0;
            msd_error_flag <= 1'b0;
            if (msd_start) n_start <= n_start + 1;
            if (msd_load)  n_load  <= n_load + 1;
            if (!msd_load && msd_data != '0) n_leak <= n_leak + 1;
            case (st_s)
                2'd0: if (msd_start) begin
                    st_op      <= msd_opcode;
                    st_s       <= 2'd1;
                    msd_load_x <= !stub_never_x;
                end
                2'd1: if (msd_load) begin
                    st_x       <= msd_data;
                    msd_load_x <= 1'b0;
                    if (st_op == 2'b01) begin
                        st_s   <= 2'd3;
                        st_cnt <= stub_latency;
                    end else begin
                        st_s       <= 2'd2;
                        msd_load_y <= 1'b1;
                    end
                end
                2'd2: if (msd_load) begin
                    st_y       <= msd_data;
                    msd_load_y <= 1'b0;
                    st_s       <= 2'd3;
                    st_cnt     <= stub_latency;
                end
                default: begin
                    if (st_cnt > 0) begin
                        st_cnt <= st_cnt - 1;
                    end else begin
                        st_s <= 2'd0;
                        case (st_op)
                            2'b00: begin
                                if (st_y == '0) begin
                                    msd_error_flag <= 1'b1;
                                    msd_result     <= '1;
                                    msd_residue    <= st_x;
                                end else begin
                                    msd_ready_flag <= 1'b1;
                                    msd_result     <= st_x / st_y;
                                    msd_residue    <= st_x % st_y;
                                end
                            end
                            2'b01: begin
                                msd_ready_flag <= 1'b1;
                                msd_result     <= isqrt(st_x);
                                msd_residue    <= st_x - isqrt(st_x) * isqrt(st_x);
                            end
                            default: begin
                                msd_ready_flag <= 1'b1;
                                msd_result     <= smul(st_x, st_y);
                                msd_residue    <= '0;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (called at a falling edge, return at a falling edge).
    // ------------------------------------------------------------------------
    // Presents a request and returns at the falling edge just after the
    // accepting rising edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] x,
                         input logic [W-1:0] y, output bit ok);
        ok         = 1'b0;
        req_opcode = op;
        req_op_x   = x;
        req_op_y   = y;
        req_valid  = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            if (req_ready === 1'b1) ok = 1'b1;
            else @(negedge clk);
        end
        if (ok) @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int budget, output int waited, output bit ok);
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        ok = (rsp_valid === 1'b1);
    endtask

    task automatic take_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_opcode = 2'b00;
        req_op_x = '0; req_op_y = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_error, rsp_timeout, msd_start, msd_load,
             msd_opcode, msd_data, rsp_result, rsp_residue} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b err=%b to=%b start=%b load=%b op=%b data=%h res=%h rsd=%h, required all 0",
                     req_ready, rsp_valid, rsp_error, rsp_timeout, msd_start, msd_load,
                     msd_opcode, msd_data, rsp_result, rsp_residue);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: got %b required 1", req_ready);
        end
    endtask

    task automatic test_multiply();
        int s_start, s_load, w;
        bit ok;
        s_start = n_start; s_load = n_load;
        issue(2'b10, 16'd7, 16'hFFFD, ok);
        // First cycle after accept: start pulse with opcode presented.
        checks++;
        if (!ok || msd_start !== 1'b1 || msd_opcode !== 2'b10) begin
            errors++;
            $display("FAIL mul_start: got accepted=%b start=%b opcode=%b required 1 1 10", ok, msd_start, msd_opcode);
        end
        @(negedge clk);
        checks++;
        if (msd_start !== 1'b0) begin
            errors++;
            $display("FAIL mul_start_width: got %b required 0", msd_start);
        end
        // load_x is already up, so the X strobe lands two cycles after start.
        @(negedge clk);
        checks++;
        if (msd_load !== 1'b1 || msd_data !== 16'd7) begin
            errors++;
            $display("FAIL mul_load_x: got load=%b data=%h required 1 0007", msd_load, msd_data);
        end
        wait_rsp(50, w, ok);
        checks++;
        if (!ok || rsp_result !== 16'hFFEB || rsp_residue !== 16'h0000 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL mul_rsp: got valid=%b res=%h rsd=%h err=%b required 1 ffeb 0000 0", ok, rsp_result, rsp_residue, rsp_error);
        end
        checks++;
        if (n_start - s_start != 1 || n_load - s_load != 2) begin
            errors++;
            $display("FAIL mul_pulses: got starts=%0d loads=%0d required 1 2", n_start - s_start, n_load - s_load);
        end
        take_rsp();
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || msd_opcode !== 2'b00) begin
            errors++;
            $display("FAIL mul_release: got valid=%b ready=%b opcode=%b required 0 1 00", rsp_valid, req_ready, msd_opcode);
        end
    endtask

    task automatic test_divide_sqrt();
        int s_load, w;
        bit ok;
        issue(2'b00, 16'd100, 16'd7, ok);
        wait_rsp(50, w, ok);
        checks++;
        if (!ok || rsp_result !== 16'd14 || rsp_residue !== 16'd2 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL div_rsp: got valid=%b res=%0d rsd=%0d err=%b required 1 14 2 0", ok, rsp_result, rsp_residue, rsp_error);
        end
        take_rsp();
        s_load = n_load;
        issue(2'b01, 16'd50, 16'd9, ok);
        wait_rsp(50, w, ok);
        checks++;
        if (!ok || rsp_result !== 16'd7 || rsp_residue !== 16'd1 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL sqrt_rsp: got valid=%b res=%0d rsd=%0d err=%b required 1 7 1 0", ok, rsp_result, rsp_residue, rsp_error);
        end
        checks++;
        if (n_load - s_load != 1) begin
            errors++;
            $display("FAIL sqrt_loads: got %0d required 1", n_load - s_load);
        end
        take_rsp();
    endtask

    task automatic test_illegal();
        int s_start;
        bit ok;
        s_start = n_start;
        issue(2'b11, 16'd5, 16'd6, ok);
        checks++;
        if (!ok || rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_result !== 16'hFFFF || rsp_residue !== 16'h0000) begin
            errors++;
            $display("FAIL illegal_rsp: got valid=%b err=%b res=%h rsd=%h required 1 1 ffff 0000", rsp_valid, rsp_error, rsp_result, rsp_residue);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_start != s_start) begin
            errors++;
            $display("FAIL illegal_no_start: got %0d starts required 0", n_start - s_start);
        end
        take_rsp();
    endtask

    task automatic test_div_zero();
        int w;
        bit ok;
        issue(2'b00, 16'd55, 16'd0, ok);
        wait_rsp(50, w, ok);
        checks++;
        if (!ok || rsp_error !== 1'b1 || rsp_timeout !== 1'b0) begin
            errors++;
            $display("FAIL divzero_rsp: got valid=%b err=%b timeout=%b required 1 1 0", ok, rsp_error, rsp_timeout);
        end
        take_rsp();
    endtask

    task automatic test_back_to_back();
        int w;
        bit ok;
        issue(2'b00, 16'd9, 16'd2, ok);
        wait_rsp(50, w, ok);
        checks++;
        if (!ok || rsp_result !== 16'd4 || rsp_residue !== 16'd1) begin
            errors++;
            $display("FAIL stall_rsp: got valid=%b res=%0d rsd=%0d required 1 4 1", ok, rsp_result, rsp_residue);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_result !== 16'd4 ||
                rsp_residue !== 16'd1 || rsp_error !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: got valid=%b ready=%b res=%0d rsd=%0d err=%b required 1 0 4 1 0",
                         i, rsp_valid, req_ready, rsp_result, rsp_residue, rsp_error);
            end
        end
        take_rsp();
        // Ready again one cycle after the handshake: the next accept is immediate.
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready: got %b required 1", req_ready);
        end
        issue(2'b01, 16'd16, 16'd0, ok);
        wait_rsp(50, w, ok);
        checks++;
        if (!ok || rsp_result !== 16'd4 || rsp_residue !== 16'd0 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL b2b_rsp: got valid=%b res=%0d rsd=%0d err=%b required 1 4 0 0", ok, rsp_result, rsp_residue, rsp_error);
        end
        take_rsp();
    endtask

    task automatic test_reset_busy();
        int s_load, w, n;
        bit ok;
        stub_latency = 30;
        s_load = n_load;
        issue(2'b00, 16'd200, 16'd9, ok);
        n = 0;
        while (n_load - s_load < 2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (n_load - s_load != 2 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstbusy_reach: got loads=%0d valid=%b required 2 0", n_load - s_load, rsp_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_error, rsp_timeout, msd_start, msd_load,
             msd_opcode, msd_data, rsp_result, rsp_residue} !== '0) begin
            errors++;
            $display("FAIL rstbusy_outputs: got ready=%b valid=%b err=%b op=%b data=%h res=%h rsd=%h required all 0",
                     req_ready, rsp_valid, rsp_error, msd_opcode, msd_data, rsp_result, rsp_residue);
        end
        @(negedge clk);
        rst = 1'b1;
        stub_latency = 2;
        @(negedge clk);
        issue(2'b00, 16'd200, 16'd9, ok);
        wait_rsp(50, w, ok);
        checks++;
        if (!ok || rsp_result !== 16'd22 || rsp_residue !== 16'd2 || rsp_error !== 1'b0) begin
            errors++;
            $display("FAIL rstbusy_next: got valid=%b res=%0d rsd=%0d err=%b required 1 22 2 0", ok, rsp_result, rsp_residue, rsp_error);
        end
        take_rsp();
    endtask

`ifdef MSD_REQ_TIMEOUT_EN
    task automatic test_timeout();
        int w;
        bit ok;
        stub_never_x = 1'b1;
        issue(2'b00, 16'd1, 16'd1, ok);
        // START occupies this cycle; eight WAIT_X cycles follow, then RESP.
        wait_rsp(30, w, ok);
        checks++;
        if (!ok || w != 9 || rsp_error !== 1'b1 || rsp_timeout !== 1'b1 ||
            rsp_result !== 16'hFFFF || rsp_residue !== 16'h0000) begin
            errors++;
            $display("FAIL timeout_rsp: got valid=%b after=%0d err=%b to=%b res=%h rsd=%h required 1 9 1 1 ffff 0000",
                     ok, w, rsp_error, rsp_timeout, rsp_result, rsp_residue);
        end
        take_rsp();
    endtask
`endif

    task automatic test_data_quiet();
        checks++;
        if (n_leak != 0) begin
            errors++;
            $display("FAIL data_quiet: got %0d nonzero msd_data cycles outside load, required 0", n_leak);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_divide_sqrt();
        test_illegal();
        test_div_zero();
        test_back_to_back();
        test_reset_busy();
        test_data_quiet();
`ifdef MSD_REQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_msd_requester
`default_nettype wire
